// File: rtl/cache_config_pkg.sv
// Shared cache geometry, trace command codes and the decoded request payload
// passed from the request frontend to the MESI cache controller.
package cache_config_pkg;

    localparam int unsigned TAG_BITS          = 12;
    localparam int unsigned INDEX_BITS        = 14;
    localparam int unsigned BLOCK_OFFSET_BITS = 6;
    localparam int unsigned CMD_BITS          = 4;
    localparam int unsigned STAT_BITS         = 32;

    typedef enum logic [CMD_BITS-1:0] {
        CMD_RD          = 4'd0,
        CMD_WR          = 4'd1,
        CMD_IFETCH      = 4'd2,
        CMD_SNOOP_INVAL = 4'd3,
        CMD_SNOOP_RD    = 4'd4,
        CMD_SNOOP_WR    = 4'd5,
        CMD_SNOOP_RWIM  = 4'd6,
        CMD_CLEAR       = 4'd8,
        CMD_PRINT       = 4'd9
    } trace_cmd_e;

    typedef struct packed {
        logic [CMD_BITS-1:0]          cmd;
        logic [TAG_BITS-1:0]          tag;
        logic [INDEX_BITS-1:0]        index;
        logic [BLOCK_OFFSET_BITS-1:0] offset;
        logic                         is_snoop;
        logic                         is_ctrl;
    } cache_req_t;

    // Codes 7 and 10-15 have no meaning in the trace format
    function automatic logic is_legal_cmd(input logic [CMD_BITS-1:0] cmd);
        return (cmd <= 4'(CMD_SNOOP_RWIM)) || (cmd == 4'(CMD_CLEAR)) || (cmd == 4'(CMD_PRINT));
    endfunction

    function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v);
        return (v == '1) ? v : v + STAT_BITS'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO of decoded cache requests; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate counter.
module sync_fifo
    import cache_config_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  cache_req_t             i_data,
    output cache_req_t             o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    cache_req_t  r_mem [DEPTH];
    logic        w_push;
    logic        w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the consumer masks the head while empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/cache_req_frontend.sv
// Trace command frontend: validates, decodes and queues requests for the cache controller.
// Optional per-class request counters are built when CACHE_REQ_STATS_EN is defined.
module cache_req_frontend
    import cache_config_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CMD_BITS-1:0]          in_cmd,
    input  logic [ADDR_BITS-1:0]         in_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CMD_BITS-1:0]          out_cmd,
    output logic [TAG_BITS-1:0]          out_tag,
    output logic [INDEX_BITS-1:0]        out_index,
    output logic [BLOCK_OFFSET_BITS-1:0] out_offset,
    output logic                         out_is_snoop,
    output logic                         out_is_ctrl,
    output logic                         err_pulse,
    output logic [$clog2(DEPTH):0]       count
`ifdef CACHE_REQ_STATS_EN
    ,
    output logic [STAT_BITS-1:0]         stat_cpu_rd,
    output logic [STAT_BITS-1:0]         stat_cpu_wr,
    output logic [STAT_BITS-1:0]         stat_snoop,
    output logic [STAT_BITS-1:0]         stat_illegal
`endif
);

    logic       w_xfer;
    logic       w_legal;
    logic       w_is_print;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    cache_req_t w_enq;
    cache_req_t w_head;
    cache_req_t w_out;
    logic       r_err;

    assign w_xfer     = in_valid && in_ready;
    assign w_legal    = is_legal_cmd(in_cmd);
    assign w_is_print = (in_cmd == 4'(CMD_PRINT));

    // Decode at enqueue so the head entry is ready the cycle after accept
    always_comb begin
        w_enq          = '0;
        w_enq.cmd      = in_cmd;
        w_enq.is_snoop = (in_cmd >= 4'(CMD_SNOOP_INVAL)) && (in_cmd <= 4'(CMD_SNOOP_RWIM));
        w_enq.is_ctrl  = (in_cmd == 4'(CMD_CLEAR)) || w_is_print;
        if (!w_is_print) begin
            w_enq.tag    = in_addr[ADDR_BITS-1 -: TAG_BITS];
            w_enq.index  = in_addr[BLOCK_OFFSET_BITS +: INDEX_BITS];
            w_enq.offset = in_addr[BLOCK_OFFSET_BITS-1:0];
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_xfer && w_legal),
        .i_pop   (w_pop),
        .i_data  (w_enq),
        .o_data  (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;

    // Stale storage is never exposed while the queue is empty
    assign w_out        = out_valid ? w_head : '0;
    assign out_cmd      = w_out.cmd;
    assign out_tag      = w_out.tag;
    assign out_index    = w_out.index;
    assign out_offset   = w_out.offset;
    assign out_is_snoop = w_out.is_snoop;
    assign out_is_ctrl  = w_out.is_ctrl;
    assign err_pulse    = r_err;

    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_xfer && !w_legal;
    end

`ifdef CACHE_REQ_STATS_EN
    logic [STAT_BITS-1:0] r_stat_cpu_rd;
    logic [STAT_BITS-1:0] r_stat_cpu_wr;
    logic [STAT_BITS-1:0] r_stat_snoop;
    logic [STAT_BITS-1:0] r_stat_illegal;

    // Counters follow accepted commands; a clear command wipes them instead of counting
    always_ff @(posedge clk) begin
        if (rst || (w_xfer && in_cmd == 4'(CMD_CLEAR))) begin
            r_stat_cpu_rd  <= '0;
            r_stat_cpu_wr  <= '0;
            r_stat_snoop   <= '0;
            r_stat_illegal <= '0;
        end else if (w_xfer) begin
            if (!w_legal)
                r_stat_illegal <= sat_inc(r_stat_illegal);
            else if (in_cmd == 4'(CMD_RD) || in_cmd == 4'(CMD_IFETCH))
                r_stat_cpu_rd <= sat_inc(r_stat_cpu_rd);
            else if (in_cmd == 4'(CMD_WR))
                r_stat_cpu_wr <= sat_inc(r_stat_cpu_wr);
            else if (w_enq.is_snoop)
                r_stat_snoop <= sat_inc(r_stat_snoop);
        end
    end

    assign stat_cpu_rd  = r_stat_cpu_rd;
    assign stat_cpu_wr  = r_stat_cpu_wr;
    assign stat_snoop   = r_stat_snoop;
    assign stat_illegal = r_stat_illegal;
`endif

endmodule

// File: tb/tb_cache_req_frontend.sv
// Self-checking bench for cache_req_frontend: decode table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_cache_req_frontend;
    import cache_config_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_cmd;
    logic [31:0]   in_addr;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_cmd;
    logic [11:0]   out_tag;
    logic [13:0]   out_index;
    logic [5:0]    out_offset;
    logic          out_is_snoop;
    logic          out_is_ctrl;
    logic          err_pulse;
    logic [CW-1:0] count;
`ifdef CACHE_REQ_STATS_EN
    logic [31:0]   stat_cpu_rd, stat_cpu_wr, stat_snoop, stat_illegal;
`endif

    cache_req_frontend #(.DEPTH(DEPTH), .ADDR_BITS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cmd       (in_cmd),
        .in_addr      (in_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_cmd      (out_cmd),
        .out_tag      (out_tag),
        .out_index    (out_index),
        .out_offset   (out_offset),
        .out_is_snoop (out_is_snoop),
        .out_is_ctrl  (out_is_ctrl),
        .err_pulse    (err_pulse),
        .count        (count)
`ifdef CACHE_REQ_STATS_EN
        ,
        .stat_cpu_rd  (stat_cpu_rd),
        .stat_cpu_wr  (stat_cpu_wr),
        .stat_snoop   (stat_snoop),
        .stat_illegal (stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic [11:0] tag;
        logic [13:0] idx;
        logic [5:0]  off;
        logic        snp;
        logic        ctl;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    cache_req_t  mq[$];
    logic        m_err;
    logic [31:0] m_rd, m_wr, m_snp, m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic cache_req_t model_dec(input logic [3:0] c, input logic [31:0] a);
        cache_req_t r;
        r.cmd      = c;
        r.is_snoop = (c >= 3) && (c <= 6);
        r.is_ctrl  = (c == 8) || (c == 9);
        if (c == 9) begin
            r.tag = '0; r.index = '0; r.offset = '0;
        end else begin
            r.tag    = 12'(a / (32'd1 << 20));
            r.index  = 14'((a / 64) % 16384);
            r.offset = 6'(a % 64);
        end
        return r;
    endfunction

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic model_edge();
        bit xfer, legal;
        if (rst) begin
            mq.delete();
            m_err = 0; m_rd = 0; m_wr = 0; m_snp = 0; m_ill = 0;
        end else begin
            xfer  = in_valid && (mq.size() < DEPTH);
            legal = !(in_cmd == 7 || in_cmd >= 10);
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            m_err = xfer && !legal;
            if (xfer && legal) mq.push_back(model_dec(in_cmd, in_addr));
            if (xfer) begin
                if (in_cmd == 8) begin
                    m_rd = 0; m_wr = 0; m_snp = 0; m_ill = 0;
                end else if (!legal)                 m_ill = sat1(m_ill);
                else if (in_cmd == 0 || in_cmd == 2) m_rd  = sat1(m_rd);
                else if (in_cmd == 1)                m_wr  = sat1(m_wr);
                else if (in_cmd >= 3 && in_cmd <= 6) m_snp = sat1(m_snp);
            end
        end
    endtask

    task automatic check_all();
        cache_req_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
        chk("count",     32'(count),     32'(mq.size()));
        chk("err_pulse", 32'(err_pulse), 32'(m_err));
        chk("out_cmd",   32'(out_cmd),   32'(h.cmd));
        chk("out_tag",   32'(out_tag),   32'(h.tag));
        chk("out_index", 32'(out_index), 32'(h.index));
        chk("out_offset",32'(out_offset),32'(h.offset));
        chk("out_is_snoop", 32'(out_is_snoop), 32'(h.is_snoop));
        chk("out_is_ctrl",  32'(out_is_ctrl),  32'(h.is_ctrl));
`ifdef CACHE_REQ_STATS_EN
        chk("stat_cpu_rd",  stat_cpu_rd,  m_rd);
        chk("stat_cpu_wr",  stat_cpu_wr,  m_wr);
        chk("stat_snoop",   stat_snoop,   m_snp);
        chk("stat_illegal", stat_illegal, m_ill);
`endif
    endtask

    // Inputs change only at posedge+1; outputs are sampled there too
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic r);
        in_valid = v; in_cmd = c; in_addr = a; out_ready = r;
    endtask

    vec_t vt[10];

    initial begin
        vt[0] = '{4'd0, 32'hABC12345, 12'hABC, 14'h048D, 6'h05, 1'b0, 1'b0};
        vt[1] = '{4'd9, 32'hFFFFFFFF, 12'h000, 14'h0000, 6'h00, 1'b0, 1'b1};
        vt[2] = '{4'd8, 32'hFFFFFFFF, 12'hFFF, 14'h3FFF, 6'h3F, 1'b0, 1'b1};
        vt[3] = '{4'd4, 32'h00000000, 12'h000, 14'h0000, 6'h00, 1'b1, 1'b0};
        vt[4] = '{4'd6, 32'h12345678, 12'h123, 14'h1159, 6'h38, 1'b1, 1'b0};
        vt[5] = '{4'd1, 32'h000FFFC0, 12'h000, 14'h3FFF, 6'h00, 1'b0, 1'b0};
        vt[6] = '{4'd2, 32'hFFF0003F, 12'hFFF, 14'h0000, 6'h3F, 1'b0, 1'b0};
        vt[7] = '{4'd3, 32'h80000040, 12'h800, 14'h0001, 6'h00, 1'b1, 1'b0};
        vt[8] = '{4'd5, 32'h00100001, 12'h001, 14'h0000, 6'h01, 1'b1, 1'b0};
        vt[9] = '{4'd0, 32'h0003FFC0, 12'h000, 14'h0FFF, 6'h00, 1'b0, 1'b0};

        rst = 1'b1;
        drive(0, 0, 0, 0);
        @(posedge clk); #1;
        step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_count",     32'(count),     0);
        rst = 1'b0;
        step();

        // Decode table: push one entry, compare against constants, pop it
        for (int i = 0; i < 10; i++) begin
            drive(1, vt[i].cmd, vt[i].addr, 0);
            step();
            drive(0, 0, 0, 0);
            chk("tbl_valid",  32'(out_valid),    1);
            chk("tbl_cmd",    32'(out_cmd),      32'(vt[i].cmd));
            chk("tbl_tag",    32'(out_tag),      32'(vt[i].tag));
            chk("tbl_index",  32'(out_index),    32'(vt[i].idx));
            chk("tbl_offset", 32'(out_offset),   32'(vt[i].off));
            chk("tbl_snoop",  32'(out_is_snoop), 32'(vt[i].snp));
            chk("tbl_ctrl",   32'(out_is_ctrl),  32'(vt[i].ctl));
            out_ready = 1;
            step();
            chk("tbl_popped", 32'(out_valid), 0);
            out_ready = 0;
        end

        // One-cycle latency with the consumer already ready
        drive(1, 4'd0, 32'hABC12345, 1);
        step();
        drive(0, 0, 0, 1);
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_tag",   32'(out_tag),   32'hABC);
        step();
        chk("lat_popped", 32'(out_valid), 0);

        // Fill to full, offer a fifth, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'(i), 32'h1000 * i, 0);
            step();
        end
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(in_ready), 0);
        drive(1, 4'd5, 32'hDEAD0000, 0);
        step();
        chk("full_ignored", 32'(count), 4);
        out_ready = 1;
        step();
        chk("full_after_pop_ready", 32'(in_ready), 1);
        chk("full_after_pop_count", 32'(count), 3);
        in_valid = 0;
        for (int i = 1; i < 4; i++) begin
            chk("drain_order", 32'(out_cmd), 32'(i));
            step();
        end
        chk("drained", 32'(out_valid), 0);

        // Illegal codes are swallowed and flagged for exactly one cycle
        drive(1, 4'd7, 32'h0, 0);
        step();
        chk("ill7_err", 32'(err_pulse), 1);
        chk("ill7_count", 32'(count), 0);
        drive(1, 4'd12, 32'h0, 0);
        step();
        chk("ill12_err", 32'(err_pulse), 1);
        in_valid = 0;
        step();
        chk("ill_err_clear", 32'(err_pulse), 0);
`ifdef CACHE_REQ_STATS_EN
        chk("stat_illegal_2", stat_illegal, 2);
`endif

        // Streaming snoops: occupancy holds at one while pointers wrap
        for (int i = 0; i < 20; i++) begin
            drive(1, 4'(3 + $urandom_range(3)), $urandom, 1);
            step();
            chk("stream_count", 32'(count), 1);
            chk("stream_snoop", 32'(out_is_snoop), 1);
        end
        drive(0, 0, 0, 1);
        step();

        // Clear command wipes statistics
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd0, $urandom, 1);
            step();
        end
`ifdef CACHE_REQ_STATS_EN
        chk("stat_rd_3", stat_cpu_rd, 3);
`endif
        drive(1, 4'd8, 32'h0, 1);
        step();
`ifdef CACHE_REQ_STATS_EN
        chk("stat_rd_clr", stat_cpu_rd, 0);
`endif
        drive(0, 0, 0, 1);
        step();

        // Reset with entries in flight
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd1, 32'h40 * i, 0);
            step();
        end
        chk("pre_rst_count", 32'(count), 3);
        drive(0, 0, 0, 0);
        rst = 1;
        step();
        rst = 0;
        chk("inrst_count", 32'(count), 0);
        chk("inrst_valid", 32'(out_valid), 0);
        chk("inrst_ready", 32'(in_ready), 1);
        chk("inrst_tag",   32'(out_tag), 0);
        step();
        drive(1, 4'd2, 32'h00ABCDEF, 0);
        step();
        chk("post_rst_count", 32'(count), 1);
        chk("post_rst_cmd",   32'(out_cmd), 2);
        out_ready = 1; in_valid = 0;
        step();

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(79) == 0);
            drive(1'($urandom_range(3) != 0), 4'($urandom), $urandom,
                  1'($urandom_range(2) != 0));
            step();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
